// File: rtl/mem_arbiter.sv
// Single-port RAM arbiter between instruction fetch and data load/store requesters.
// Optional macro ARB_STARVE_GUARD_EN bounds consecutive data grants while a fetch waits.
module mem_arbiter #(
  parameter int unsigned ADDR_W       = 32,
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              halt,
  input  logic              iREN,
  input  logic [ADDR_W-1:0] iaddr,
  input  logic              dREN,
  input  logic              dWEN,
  input  logic [ADDR_W-1:0] daddr,
  input  logic [DATA_W-1:0] dstore,
  output logic              ihit,
  output logic [DATA_W-1:0] iload,
  output logic              dhit,
  output logic [DATA_W-1:0] dload,
  output logic              ramREN,
  output logic              ramWEN,
  output logic [ADDR_W-1:0] ramaddr,
  output logic [DATA_W-1:0] ramstore,
  input  logic [DATA_W-1:0] ramload,
  input  logic [1:0]        ramstate,
  output logic              err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    IGNT = 2'd1,
    DGNT = 2'd2
  } state_e;

  localparam logic [1:0] RS_ACCESS = 2'd2;
  localparam logic [1:0] RS_ERROR  = 2'd3;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   store_q, store_d;
  logic                wr_q, wr_d;
  logic                i_want, d_want, starve_force;

  assign i_want = iREN & ~halt;
  assign d_want = dREN | dWEN;

`ifdef ARB_STARVE_GUARD_EN
  localparam int unsigned CNT_W = $clog2(STARVE_LIMIT + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign starve_force = i_want && (cnt_q >= CNT_W'(STARVE_LIMIT));

  // Counts data completions that overtook a pending, unhalted fetch.
  always_comb begin
    cnt_d = cnt_q;
    if (!iREN) begin
      cnt_d = '0;
    end else if (state_q == IDLE && state_d == IGNT) begin
      cnt_d = '0;
    end else if (dhit && !halt && (cnt_q < CNT_W'(STARVE_LIMIT))) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  localparam int unsigned unused_starve_limit = STARVE_LIMIT;

  assign starve_force = 1'b0;
`endif

  // Next-state and RAM-facing outputs; everything idles at zero.
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    store_d  = store_q;
    wr_d     = wr_q;
    ihit     = 1'b0;
    iload    = '0;
    dhit     = 1'b0;
    dload    = '0;
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = '0;
    ramstore = '0;
    err      = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (d_want && !starve_force) begin
          state_d = DGNT;
          addr_d  = daddr;
          store_d = dstore;
          wr_d    = dWEN;
        end else if (i_want) begin
          state_d = IGNT;
          addr_d  = iaddr;
          store_d = '0;
          wr_d    = 1'b0;
        end
      end

      IGNT: begin
        // halt is ignored here so an in-flight fetch can finish.
        if (!iREN) begin
          state_d = IDLE;
        end else begin
          ramREN  = 1'b1;
          ramaddr = addr_q;
          iload   = ramload;
          if (ramstate == RS_ACCESS) begin
            ihit    = 1'b1;
            state_d = IDLE;
          end else if (ramstate == RS_ERROR) begin
            err     = 1'b1;
            state_d = IDLE;
          end
        end
      end

      DGNT: begin
        if (!d_want) begin
          state_d = IDLE;
        end else begin
          ramREN   = ~wr_q;
          ramWEN   = wr_q;
          ramaddr  = addr_q;
          ramstore = store_q;
          dload    = wr_q ? '0 : ramload;
          if (ramstate == RS_ACCESS) begin
            dhit    = 1'b1;
            state_d = IDLE;
          end else if (ramstate == RS_ERROR) begin
            err     = 1'b1;
            state_d = IDLE;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      addr_q  <= '0;
      store_q <= '0;
      wr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      store_q <= store_d;
      wr_q    <= wr_d;
    end
  end

endmodule
